alu_share_arbiter: RTL and testbench

- Shares the single combinational ArithmeticLogicUnit instance between two requesters, for example the execute stage (port 0) and a debug/CSR helper (port 1).
- Each requester has a valid/ready request channel and a valid/ready response channel.
- Grants are round-robin with one operation in flight.
- Operands are registered before they reach the ALU, and the result and zero flag are registered back to the granted requester.
- Unsupported function codes are flagged as errors.

---
 rtl/alu_share_arbiter_pkg.sv | 29 ++
 rtl/alu_share_arbiter_if.sv | 27 ++
 rtl/alu_share_arbiter_rr_arb2.sv | 18 +
 rtl/alu_share_arbiter.sv | 102 ++++++++++
 tb/tb_alu_share_arbiter.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_share_arbiter_pkg.sv
// Shared ALU definitions: function codes, the supported-code check and the
// arbiter state type used by the ALU sharing logic.
package alu_pkg;

  localparam int ALU_WIDTH = 32;
  localparam int ALU_FUN_W = 3;

  typedef logic [2:0] alu_fun_t;

  localparam alu_fun_t ALU_ADD = 3'b000;
  localparam alu_fun_t ALU_SUB = 3'b001;
  localparam alu_fun_t ALU_AND = 3'b010;
  localparam alu_fun_t ALU_OR  = 3'b011;
  localparam alu_fun_t ALU_SLT = 3'b101;

  // Codes outside this set still run through the ALU, but the response is
  // flagged as an error.
  function automatic logic alu_fun_valid(input alu_fun_t fun);
    return (fun == ALU_ADD) || (fun == ALU_SUB) || (fun == ALU_AND) ||
           (fun == ALU_OR)  || (fun == ALU_SLT);
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Two-requester request/response bundle for the shared ALU. Requester i
// occupies bit i of the handshake vectors and slice i of the packed buses.
interface alu_share_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int FUN_W = 3
);
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [2*WIDTH-1:0] req_src_a;
  logic [2*WIDTH-1:0] req_src_b;
  logic [2*FUN_W-1:0] req_fun;
  logic [1:0]         rsp_valid;
  logic [1:0]         rsp_ready;
  logic [WIDTH-1:0]   rsp_result;
  logic               rsp_zero;
  logic               rsp_err;

  modport master (
    output req_valid, req_src_a, req_src_b, req_fun, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err
  );

  modport slave (
    input  req_valid, req_src_a, req_src_b, req_fun, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err
  );
endinterface

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-input round-robin grant: a lone request always wins; on contention
// the requester named by ptr wins. Purely combinational so other shared
// resources can reuse it with their own pointer register.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] grant
);

  // One-hot grant, pointer only breaks ties.
  always_comb begin
    grant = req;
    if (&req) begin
      grant = ptr ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two requesters. One operation is in
// flight at a time: operands are captured at the request handshake, fed to
// the ALU for exactly one cycle, and the result is held for the granted
// requester until it accepts it.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int FUN_W = 3
) (
  input  logic                CLK,
  input  logic                RST_N,
  alu_share_arbiter_if.slave  bus,
  output logic [WIDTH-1:0]    alu_src_a,
  output logic [WIDTH-1:0]    alu_src_b,
  output logic [FUN_W-1:0]    alu_fun,
  input  logic [WIDTH-1:0]    alu_result,
  input  logic                alu_zero
);

  arb_state_t       state;
  logic             ptr;
  logic             gnt_idx;
  logic [1:0]       grant;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [FUN_W-1:0] op_fun;
  logic [1:0]       rsp_valid_q;
  logic [WIDTH-1:0] rsp_result_q;
  logic             rsp_zero_q;
  logic             rsp_err_q;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [FUN_W-1:0] sel_fun;

  rr_arb2 u_rr_arb2 (
    .req   (bus.req_valid),
    .ptr   (ptr),
    .grant (grant)
  );

  // Gated by RST_N so nothing is accepted while reset is held.
  assign bus.req_ready = (state == IDLE && RST_N) ? grant : 2'b00;

  assign sel_a   = grant[1] ? bus.req_src_a[2*WIDTH-1:WIDTH] : bus.req_src_a[WIDTH-1:0];
  assign sel_b   = grant[1] ? bus.req_src_b[2*WIDTH-1:WIDTH] : bus.req_src_b[WIDTH-1:0];
  assign sel_fun = grant[1] ? bus.req_fun[2*FUN_W-1:FUN_W]   : bus.req_fun[FUN_W-1:0];

  // ALU inputs sit at ADD 0+0 outside EXEC so the shared ALU stays quiet.
  assign alu_src_a = (state == EXEC) ? op_a   : '0;
  assign alu_src_b = (state == EXEC) ? op_b   : '0;
  assign alu_fun   = (state == EXEC) ? op_fun : '0;

  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_zero   = rsp_zero_q;
  assign bus.rsp_err    = rsp_err_q;

  // Sequencer: accept, execute one cycle, hold the response until taken.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state        <= IDLE;
      ptr          <= 1'b0;
      gnt_idx      <= 1'b0;
      op_a         <= '0;
      op_b         <= '0;
      op_fun       <= '0;
      rsp_valid_q  <= 2'b00;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|bus.req_ready) begin
            op_a    <= sel_a;
            op_b    <= sel_b;
            op_fun  <= sel_fun;
            gnt_idx <= grant[1];
            state   <= EXEC;
          end
        end
        EXEC: begin
          rsp_result_q <= alu_result;
          rsp_zero_q   <= alu_zero;
          rsp_err_q    <= !alu_fun_valid(op_fun);
          rsp_valid_q  <= gnt_idx ? 2'b10 : 2'b01;
          state        <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready[gnt_idx]) begin
            rsp_valid_q <= 2'b00;
            ptr         <= ~gnt_idx;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: a stand-in ALU, directed scenarios and
// randomized rounds checked against a request-level reference model.
module tb_alu_share_arbiter;

  localparam int WIDTH = 32;
  localparam int FUN_W = 3;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  alu_share_arbiter_if #(.WIDTH(WIDTH), .FUN_W(FUN_W)) bus ();

  logic [WIDTH-1:0] alu_src_a, alu_src_b, alu_result;
  logic [FUN_W-1:0] alu_fun;
  logic             alu_zero;

  alu_share_arbiter #(.WIDTH(WIDTH), .FUN_W(FUN_W)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .bus        (bus),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_fun    (alu_fun),
    .alu_result (alu_result),
    .alu_zero   (alu_zero)
  );

  // ALU behaviour: the five supported operations, 0xBAD00BAD otherwise.
  function automatic logic [31:0] ref_alu(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b101:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'hBAD00BAD;
    endcase
  endfunction

  function automatic logic fun_ok(input logic [2:0] f);
    return (f == 3'b000) || (f == 3'b001) || (f == 3'b010) || (f == 3'b011) || (f == 3'b101);
  endfunction

  function automatic logic [1:0] onehot(input int i);
    return (i == 1) ? 2'b10 : 2'b01;
  endfunction

  // Stand-in for the shared ALU instance.
  always_comb begin
    alu_result = ref_alu(alu_fun, alu_src_a, alu_src_b);
    alu_zero   = (alu_result == 32'd0);
  end

  int passed = 0;
  int total  = 0;
  int model_ptr = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_req(input int p, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    bus.req_fun[p*3 +: 3]    = f;
    bus.req_src_a[p*32 +: 32] = a;
    bus.req_src_b[p*32 +: 32] = b;
  endtask

  // One complete operation: requests in mask, winner from the model pointer,
  // response held for stall cycles before being accepted.
  task automatic run_round(input logic [1:0] mask, input int stall);
    int w;
    logic [31:0] ea, eb, er;
    logic [2:0]  ef;
    w  = (mask == 2'b11) ? model_ptr : (mask[1] ? 1 : 0);
    ea = bus.req_src_a[w*32 +: 32];
    eb = bus.req_src_b[w*32 +: 32];
    ef = bus.req_fun[w*3 +: 3];
    er = ref_alu(ef, ea, eb);
    bus.req_valid = mask;
    #1;
    check("req_ready_grant", {30'b0, bus.req_ready}, {30'b0, onehot(w)});
    check("alu_quiet_idle", {31'b0, |{alu_src_a, alu_src_b, alu_fun}}, 32'd0);
    tick();
    bus.req_valid[w] = 1'b0;
    bus.req_src_a[w*32 +: 32] = ~ea ^ $urandom;
    bus.req_src_b[w*32 +: 32] = ~eb;
    bus.req_fun[w*3 +: 3]     = ~ef;
    #1;
    check("exec_rsp_valid", {30'b0, bus.rsp_valid}, 32'd0);
    check("exec_req_ready", {30'b0, bus.req_ready}, 32'd0);
    check("exec_alu_a", alu_src_a, ea);
    check("exec_alu_b", alu_src_b, eb);
    check("exec_alu_fun", {29'b0, alu_fun}, {29'b0, ef});
    tick();
    check("rsp_valid", {30'b0, bus.rsp_valid}, {30'b0, onehot(w)});
    check("rsp_result", bus.rsp_result, er);
    check("rsp_zero", {31'b0, bus.rsp_zero}, {31'b0, er == 32'd0});
    check("rsp_err", {31'b0, bus.rsp_err}, {31'b0, !fun_ok(ef)});
    for (int s = 0; s < stall; s++) begin
      bus.rsp_ready = onehot(1 - w);
      tick();
      check("hold_rsp_valid", {30'b0, bus.rsp_valid}, {30'b0, onehot(w)});
      check("hold_rsp_result", bus.rsp_result, er);
      check("hold_req_ready", {30'b0, bus.req_ready}, 32'd0);
      check("alu_quiet_resp", {31'b0, |{alu_src_a, alu_src_b, alu_fun}}, 32'd0);
    end
    bus.rsp_ready = onehot(w);
    tick();
    bus.rsp_ready = 2'b00;
    check("done_rsp_valid", {30'b0, bus.rsp_valid}, 32'd0);
    model_ptr = 1 - w;
    bus.req_valid = 2'b00;
  endtask

  task automatic pulse_reset();
    RST_N = 1'b0;
    #3;
    RST_N = 1'b1;
    tick();
    model_ptr = 0;
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb;
    bus.req_valid = 2'b00;
    bus.req_src_a = '0;
    bus.req_src_b = '0;
    bus.req_fun   = '0;
    bus.rsp_ready = 2'b00;
    RST_N = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("reset_rsp_valid", {30'b0, bus.rsp_valid}, 32'd0);
    check("reset_req_ready", {30'b0, bus.req_ready}, 32'd0);
    check("reset_result", bus.rsp_result, 32'd0);
    check("reset_flags", {30'b0, bus.rsp_zero, bus.rsp_err}, 32'd0);
    check("reset_alu", {31'b0, |{alu_src_a, alu_src_b, alu_fun}}, 32'd0);
    RST_N = 1'b1;
    tick();

    // Lone requester 0: ADD 5+7.
    drive_req(0, 3'b000, 32'd5, 32'd7);
    run_round(2'b01, 0);

    // Contention after reset: 0,1,0.
    pulse_reset();
    drive_req(0, 3'b001, 32'd9, 32'd9);
    drive_req(1, 3'b011, 32'h0000_00F0, 32'h0000_000F);
    run_round(2'b11, 0);
    drive_req(1, 3'b011, 32'h0000_00F0, 32'h0000_000F);
    run_round(2'b11, 0);
    drive_req(0, 3'b001, 32'd9, 32'd9);
    drive_req(1, 3'b011, 32'h0000_00F0, 32'h0000_000F);
    run_round(2'b11, 1);

    // Backpressure on requester 1: SLT -1 < 1.
    drive_req(1, 3'b101, 32'hFFFF_FFFF, 32'd1);
    run_round(2'b10, 5);

    // Unsupported function code, then a normal ADD.
    drive_req(0, 3'b111, 32'd1, 32'd2);
    run_round(2'b01, 0);
    drive_req(0, 3'b000, 32'd1, 32'd2);
    run_round(2'b01, 0);

    // Reset mid-EXEC.
    drive_req(0, 3'b000, 32'd3, 32'd4);
    bus.req_valid = 2'b01;
    tick();
    bus.req_valid = 2'b11;
    #2;
    RST_N = 1'b0;
    #1;
    check("rst_exec_rsp_valid", {30'b0, bus.rsp_valid}, 32'd0);
    check("rst_exec_req_ready", {30'b0, bus.req_ready}, 32'd0);
    check("rst_exec_alu_a", alu_src_a, 32'd0);
    check("rst_exec_result", bus.rsp_result, 32'd0);
    bus.req_valid = 2'b00;
    tick();
    RST_N = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rst_exec_no_rsp", {30'b0, bus.rsp_valid}, 32'd0);
    end

    // Reset mid-RESP.
    drive_req(1, 3'b001, 32'd10, 32'd3);
    bus.req_valid = 2'b10;
    tick();
    bus.req_valid = 2'b00;
    tick();
    check("pre_rst_rsp_valid", {30'b0, bus.rsp_valid}, 32'h2);
    #2;
    RST_N = 1'b0;
    #1;
    check("rst_resp_rsp_valid", {30'b0, bus.rsp_valid}, 32'd0);
    check("rst_resp_result", bus.rsp_result, 32'd0);
    tick();
    RST_N = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rst_resp_no_rsp", {30'b0, bus.rsp_valid}, 32'd0);
    end
    model_ptr = 0;
    drive_req(0, 3'b000, 32'd20, 32'd22);
    drive_req(1, 3'b000, 32'd30, 32'd33);
    run_round(2'b11, 0);

    // Operands change right after acceptance.
    drive_req(0, 3'b010, 32'hFF00_FF00, 32'h0FF0_0FF0);
    run_round(2'b01, 2);

    // Randomized rounds.
    for (int r = 0; r < 40; r++) begin
      for (int p = 0; p < 2; p++) begin
        ra = rand_operand();
        rb = ($urandom_range(0, 4) == 0) ? ra : rand_operand();
        drive_req(p, 3'($urandom_range(0, 7)), ra, rb);
      end
      run_round(2'($urandom_range(1, 3)), $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
